// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, writeback select codes and arbiter states
package wb_pkg;
  localparam int XLEN_DEF = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [1:0] WB_SEL_MEM = 2'b00;
  localparam logic [1:0] WB_SEL_ALU = 2'b01;
  typedef enum logic {WBA_PIPE, WBA_DRAIN} wba_state_e;
endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: synchronous FIFO of late {rd, data} results
module wb_result_fifo import wb_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push_i,
  input  logic                            pop_i,
  input  logic [REG_ADDR_W-1:0]           push_rd_i,
  input  logic [XLEN-1:0]                 push_data_i,
  output logic                            full_o,
  output logic                            empty_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
  output logic [REG_ADDR_W-1:0]           head_rd_o,
  output logic [XLEN-1:0]                 head_data_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  logic [REG_ADDR_W+XLEN-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  assign full_o = count_q == CW'(FIFO_DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign {head_rd_o, head_data_o} = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= {push_rd_i, push_data_i};
        wr_q <= wr_q + AW'(1);
      end
      if (pop_i) rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between pipeline writeback and late multi-cycle results
module wb_port_arbiter import wb_pkg::*; #(
  parameter int XLEN = XLEN_DEF,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr_rd,
  input  logic [1:0]            wb_select,
  input  logic [XLEN-1:0]       wb_mem_out,
  input  logic [XLEN-1:0]       wb_alu_out,
  output logic                  wb_stall,
  input  logic                  mc_valid,
  output logic                  mc_ready,
  input  logic [REG_ADDR_W-1:0] mc_rd,
  input  logic [XLEN-1:0]       mc_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_addr,
  output logic [XLEN-1:0]       rf_wdata
);
  localparam int SW = $clog2(STARVE_LIMIT+1);
  wba_state_e state_q, state_d;
  logic [SW-1:0] starve_q, starve_d, starve_inc;
  logic full, empty, fifo_gnt, pipe_gnt, lose, wr_en;
  logic [$clog2(FIFO_DEPTH+1)-1:0] count;
  logic [REG_ADDR_W-1:0] head_rd, wr_rd;
  logic [XLEN-1:0] head_data, wr_data;
  assign mc_ready = !rst && !full;
  assign wb_stall = state_q == WBA_DRAIN;
  wb_result_fifo #(.XLEN(XLEN), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(mc_valid && mc_ready),
    .pop_i(fifo_gnt),
    .push_rd_i(mc_rd),
    .push_data_i(mc_data),
    .full_o(full),
    .empty_o(empty),
    .count_o(count),
    .head_rd_o(head_rd),
    .head_data_o(head_data)
  );
  always_comb begin
    fifo_gnt = state_q == WBA_DRAIN ? !empty : !wb_valid && !empty;
    pipe_gnt = state_q == WBA_PIPE && wb_valid;
    lose = pipe_gnt && !empty;
    starve_inc = starve_q + SW'(1);
    state_d = lose && starve_inc == SW'(STARVE_LIMIT) ? WBA_DRAIN : WBA_PIPE;
    starve_d = lose && state_d == WBA_PIPE ? starve_inc : '0;
    wr_rd = fifo_gnt ? head_rd : wb_addr_rd;
    wr_data = fifo_gnt ? head_data :
              wb_select == WB_SEL_MEM ? wb_mem_out :
              wb_select == WB_SEL_ALU ? wb_alu_out : '0;
    wr_en = (fifo_gnt || pipe_gnt) && wr_rd != '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WBA_PIPE;
      starve_q <= '0;
      rf_we <= 1'b0;
      rf_addr <= '0;
      rf_wdata <= '0;
    end else begin
      state_q <= state_d;
      starve_q <= starve_d;
      rf_we <= wr_en;
      if (wr_en) begin
        rf_addr <= wr_rd;
        rf_wdata <= wr_data;
      end
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic wb_valid = 1'b0, mc_valid = 1'b0;
  logic [4:0] wb_addr_rd = '0, mc_rd = '0;
  logic [1:0] wb_select = '0;
  logic [31:0] wb_mem_out = '0, wb_alu_out = '0, mc_data = '0;
  logic wb_stall, mc_ready, rf_we;
  logic [4:0] rf_addr;
  logic [31:0] rf_wdata;
  int pass_cnt = 0, total_cnt = 0;
  always #5 clk = ~clk;
  wb_port_arbiter #(.XLEN(32), .FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_addr_rd(wb_addr_rd),
    .wb_select(wb_select), .wb_mem_out(wb_mem_out), .wb_alu_out(wb_alu_out),
    .wb_stall(wb_stall), .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd),
    .mc_data(mc_data), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total_cnt++; if (rf_we !== 1'b0) $display("FAIL reset_we got %b exp 0", rf_we); else pass_cnt++;
    total_cnt++; if (rf_addr !== 5'd0) $display("FAIL reset_addr got %0d exp 0", rf_addr); else pass_cnt++;
    total_cnt++; if (rf_wdata !== 32'h0) $display("FAIL reset_wdata got %h exp 0", rf_wdata); else pass_cnt++;
    total_cnt++; if (wb_stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", wb_stall); else pass_cnt++;
    total_cnt++; if (mc_ready !== 1'b0) $display("FAIL reset_mc_ready got %b exp 0", mc_ready); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++; if (mc_ready !== 1'b1) $display("FAIL post_reset_mc_ready got %b exp 1", mc_ready); else pass_cnt++;
  endtask
  task automatic test_pipe_select();
    wb_valid = 1'b1; wb_addr_rd = 5'b10101; wb_select = 2'b00; wb_mem_out = 32'hAAAAAAAA; wb_alu_out = 32'h11111111;
    tick();
    total_cnt++; if (rf_we !== 1'b1 || rf_addr !== 5'd21 || rf_wdata !== 32'hAAAAAAAA)
      $display("FAIL sel_mem got we=%b addr=%0d data=%h exp we=1 addr=21 data=aaaaaaaa", rf_we, rf_addr, rf_wdata); else pass_cnt++;
    wb_addr_rd = 5'd27; wb_select = 2'b01; wb_alu_out = 32'h55555555;
    tick();
    total_cnt++; if (rf_we !== 1'b1 || rf_addr !== 5'd27 || rf_wdata !== 32'h55555555)
      $display("FAIL sel_alu got we=%b addr=%0d data=%h exp we=1 addr=27 data=55555555", rf_we, rf_addr, rf_wdata); else pass_cnt++;
    wb_addr_rd = 5'd28; wb_select = 2'b10;
    tick();
    total_cnt++; if (rf_we !== 1'b1 || rf_addr !== 5'd28 || rf_wdata !== 32'h0)
      $display("FAIL sel_10 got we=%b addr=%0d data=%h exp we=1 addr=28 data=0", rf_we, rf_addr, rf_wdata); else pass_cnt++;
    wb_select = 2'b11; wb_mem_out = 32'hDEADBEEF;
    tick();
    total_cnt++; if (rf_we !== 1'b1 || rf_wdata !== 32'h0)
      $display("FAIL sel_11 got we=%b data=%h exp we=1 data=0", rf_we, rf_wdata); else pass_cnt++;
    wb_addr_rd = 5'd0; wb_select = 2'b01; wb_alu_out = 32'h77777777;
    tick();
    total_cnt++; if (rf_we !== 1'b0) $display("FAIL x0_we got %b exp 0", rf_we); else pass_cnt++;
    total_cnt++; if (rf_addr !== 5'd28 || rf_wdata !== 32'h0)
      $display("FAIL x0_hold got addr=%0d data=%h exp addr=28 data=0", rf_addr, rf_wdata); else pass_cnt++;
    wb_valid = 1'b0;
    tick();
    total_cnt++; if (rf_we !== 1'b0) $display("FAIL idle_we got %b exp 0", rf_we); else pass_cnt++;
  endtask
  task automatic test_mc_single();
    total_cnt++; if (mc_ready !== 1'b1) $display("FAIL mc_ready_empty got %b exp 1", mc_ready); else pass_cnt++;
    mc_valid = 1'b1; mc_rd = 5'd3; mc_data = 32'h12345678;
    tick();
    mc_valid = 1'b0;
    total_cnt++; if (rf_we !== 1'b0) $display("FAIL mc_early got we=%b exp 0", rf_we); else pass_cnt++;
    tick();
    total_cnt++; if (rf_we !== 1'b1 || rf_addr !== 5'd3 || rf_wdata !== 32'h12345678)
      $display("FAIL mc_write got we=%b addr=%0d data=%h exp we=1 addr=3 data=12345678", rf_we, rf_addr, rf_wdata); else pass_cnt++;
    tick();
    total_cnt++; if (rf_we !== 1'b0) $display("FAIL mc_after got we=%b exp 0", rf_we); else pass_cnt++;
  endtask
  task automatic test_full_and_starve();
    logic exp_stall;
    logic [4:0] exp_addr;
    logic [31:0] exp_data;
    wb_valid = 1'b1; wb_addr_rd = 5'd9; wb_select = 2'b01; wb_alu_out = 32'h99999999;
    for (int i = 1; i <= 16; i++) begin
      mc_valid = i <= 3;
      mc_rd = 5'(i + 3);
      mc_data = 32'h11 * (i + 3);
      tick();
      exp_stall = i == 5 || i == 10;
      exp_addr = i == 6 ? 5'd4 : i == 11 ? 5'd5 : 5'd9;
      exp_data = i == 6 ? 32'h44 : i == 11 ? 32'h55 : 32'h99999999;
      total_cnt++; if (wb_stall !== exp_stall) $display("FAIL starve_stall[%0d] got %b exp %b", i, wb_stall, exp_stall); else pass_cnt++;
      total_cnt++; if (rf_we !== 1'b1 || rf_addr !== exp_addr || rf_wdata !== exp_data)
        $display("FAIL starve_write[%0d] got we=%b addr=%0d data=%h exp we=1 addr=%0d data=%h", i, rf_we, rf_addr, rf_wdata, exp_addr, exp_data); else pass_cnt++;
      if (i == 1 || i == 2 || i == 11) begin
        total_cnt++; if (mc_ready !== (i != 2)) $display("FAIL fill_ready[%0d] got %b exp %b", i, mc_ready, i != 2); else pass_cnt++;
      end
    end
    mc_valid = 1'b0;
    wb_valid = 1'b0;
    tick();
    tick();
    total_cnt++; if (rf_we !== 1'b0) $display("FAIL refused_not_stored got we=%b addr=%0d exp we=0", rf_we, rf_addr); else pass_cnt++;
  endtask
  task automatic test_reset_mid();
    wb_valid = 1'b1; wb_addr_rd = 5'd9; wb_select = 2'b01;
    for (int i = 1; i <= 5; i++) begin
      mc_valid = i <= 2;
      mc_rd = 5'(i + 6);
      mc_data = 32'hA0 + i;
      tick();
    end
    mc_valid = 1'b0;
    total_cnt++; if (wb_stall !== 1'b1 || mc_ready !== 1'b0)
      $display("FAIL pre_rst got stall=%b ready=%b exp stall=1 ready=0", wb_stall, mc_ready); else pass_cnt++;
    rst = 1'b1;
    tick();
    total_cnt++; if (rf_we !== 1'b0 || rf_addr !== 5'd0 || rf_wdata !== 32'h0 || wb_stall !== 1'b0 || mc_ready !== 1'b0)
      $display("FAIL mid_rst got we=%b addr=%0d data=%h stall=%b ready=%b exp all 0", rf_we, rf_addr, rf_wdata, wb_stall, mc_ready); else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++; if (mc_ready !== 1'b1) $display("FAIL rst_empty_ready got %b exp 1", mc_ready); else pass_cnt++;
    wb_addr_rd = 5'd12; wb_alu_out = 32'hC0FFEE00;
    for (int i = 0; i < 6; i++) begin
      tick();
      total_cnt++; if (wb_stall !== 1'b0 || rf_we !== 1'b1 || rf_addr !== 5'd12 || rf_wdata !== 32'hC0FFEE00)
        $display("FAIL post_rst_write[%0d] got stall=%b we=%b addr=%0d data=%h exp stall=0 we=1 addr=12 data=c0ffee00", i, wb_stall, rf_we, rf_addr, rf_wdata); else pass_cnt++;
    end
    wb_valid = 1'b0;
    tick();
    tick();
    total_cnt++; if (rf_we !== 1'b0) $display("FAIL rst_discard got we=%b addr=%0d exp we=0", rf_we, rf_addr); else pass_cnt++;
  endtask
  initial begin
    test_reset();
    test_pipe_select();
    test_mc_single();
    test_full_and_starve();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
